// File: rtl/qspi_mm_ctrl.sv
// qspi_mm_ctrl
// QSPI (4-bit) slave front end for a small matrix-multiply datapath.
// The host opens a frame with cs_n low and sends a command byte as two
// nibbles sampled on sclk rises:
//   0x01 LOAD : following bytes are written to operand slots 0..7
//   0x02 RUN  : pulse mm_start (unless a compute is already in flight)
//   0x03 READ : two turnaround rises, then 16 result nibbles on sclk falls
//   0x04 STAT : two turnaround rises, then the byte {7'b0, busy}
//   other     : rest of the frame is ignored
// sclk and cs_n are asynchronous and oversampled by clk (f_clk >= 8 f_sclk).
//
// Ports
//   clk, rst               system clock, synchronous active-high reset
//   cs_n, sclk, sio_in     QSPI inputs (asynchronous to clk)
//   sio_out, sio_oe        QSPI data-out nibble and its drive enable
//   wr_en/wr_addr/wr_data  operand write port into the datapath
//   mm_start, mm_done      compute start pulse out / complete pulse in
//   rd_addr, rd_data       result-word select / word (valid 1 clk later)
//   busy                   a compute is in flight
module qspi_mm_ctrl #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cs_n,
  input  logic        sclk,
  input  logic [3:0]  sio_in,
  output logic [3:0]  sio_out,
  output logic        sio_oe,
  output logic        wr_en,
  output logic [2:0]  wr_addr,
  output logic [7:0]  wr_data,
  output logic        mm_start,
  input  logic        mm_done,
  output logic [1:0]  rd_addr,
  input  logic [15:0] rd_data,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_LOAD, S_RUN, S_TURN, S_READ, S_STAT, S_IGNORE
  } state_t;

  // Stage p0: input synchronizers and edge detection
  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] cs_sync;
  logic [SYNC_STAGES-1:0] flush_sr;
  logic sclk_prev, cs_prev, cs_armed;
  logic sclk_s, cs_s, flushed;
  logic sclk_rise, sclk_fall, cs_fall;

  assign sclk_s  = sclk_sync[SYNC_STAGES-1];
  assign cs_s    = cs_sync[SYNC_STAGES-1];
  // flush_sr marks the cycle from which cs_s reflects the real pin rather
  // than the reset value of the synchronizer.
  assign flushed = flush_sr[SYNC_STAGES-1];

  assign sclk_rise = sclk_s & ~sclk_prev;
  assign sclk_fall = ~sclk_s & sclk_prev;
  // A frame only starts from a genuine high->low of cs_n after reset; a
  // cs_n that is already low when reset releases must not open a frame,
  // so falls are accepted only once cs_n has been seen high.
  assign cs_fall   = ~cs_s & cs_prev & cs_armed;

  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_sync <= '0;
      cs_sync   <= '1;
      flush_sr  <= '0;
      sclk_prev <= 1'b0;
      cs_prev   <= 1'b1;
      cs_armed  <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n};
      flush_sr  <= {flush_sr[SYNC_STAGES-2:0], 1'b1};
      sclk_prev <= sclk_s;
      cs_prev   <= cs_s;
      if (flushed && cs_s) cs_armed <= 1'b1;
    end
  end

  // Stage p1: frame FSM and registered outputs
  state_t      state_q, state_d;
  logic        nib_q, nib_d;
  logic [3:0]  hi_q, hi_d;
  logic [3:0]  wr_cnt_q, wr_cnt_d;
  logic        turn_q, turn_d;
  logic        is_stat_q, is_stat_d;
  logic [4:0]  out_cnt_q, out_cnt_d;
  logic [15:0] shift_q, shift_d;
  logic        adv_q, adv_d;
  logic [3:0]  sio_out_q, sio_out_d;
  logic        sio_oe_q, sio_oe_d;
  logic        wr_en_q, wr_en_d;
  logic [2:0]  wr_addr_q, wr_addr_d;
  logic [7:0]  wr_data_q, wr_data_d;
  logic        mm_start_q, mm_start_d;
  logic [1:0]  rd_addr_q, rd_addr_d;
  logic        busy_q, busy_d;

  logic        byte_done;
  logic [7:0]  byte_val;

  // High nibble arrives first; the byte completes on the second rise.
  assign byte_done = sclk_rise & nib_q;
  assign byte_val  = {hi_q, sio_in};

  always_comb begin
    state_d    = state_q;
    nib_d      = nib_q;
    hi_d       = hi_q;
    wr_cnt_d   = wr_cnt_q;
    turn_d     = turn_q;
    is_stat_d  = is_stat_q;
    out_cnt_d  = out_cnt_q;
    shift_d    = shift_q;
    adv_d      = 1'b0;
    sio_out_d  = sio_out_q;
    sio_oe_d   = sio_oe_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    mm_start_d = 1'b0;
    rd_addr_d  = rd_addr_q;

    // The word after the one just started is selected one clk after its
    // predecessor's first nibble, leaving three falls for rd_data to settle.
    if (adv_q && rd_addr_q != 2'd3) rd_addr_d = rd_addr_q + 2'd1;

    if (cs_s) begin
      state_d   = S_IDLE;
      nib_d     = 1'b0;
      wr_cnt_d  = 4'd0;
      turn_d    = 1'b0;
      out_cnt_d = 5'd0;
      sio_oe_d  = 1'b0;
      sio_out_d = 4'h0;
    end else begin
      if ((state_q == S_CMD || state_q == S_LOAD) && sclk_rise) begin
        if (!nib_q) begin
          hi_d  = sio_in;
          nib_d = 1'b1;
        end else begin
          nib_d = 1'b0;
        end
      end

      case (state_q)
        S_IDLE: begin
          if (cs_fall) begin
            state_d  = S_CMD;
            nib_d    = 1'b0;
            wr_cnt_d = 4'd0;
          end
        end

        S_CMD: begin
          if (byte_done) begin
            case (byte_val)
              8'h01: state_d = S_LOAD;
              8'h02: begin
                state_d = S_RUN;
                if (!busy_q) mm_start_d = 1'b1;
              end
              8'h03, 8'h04: begin
                state_d   = S_TURN;
                turn_d    = 1'b0;
                is_stat_d = (byte_val == 8'h04);
                rd_addr_d = 2'd0;
                sio_oe_d  = 1'b0;
              end
              default: state_d = S_IGNORE;
            endcase
          end
        end

        S_LOAD: begin
          if (byte_done && wr_cnt_q < 4'd8) begin
            wr_cnt_d = wr_cnt_q + 4'd1;
            if (!busy_q) begin
              wr_en_d   = 1'b1;
              wr_addr_d = wr_cnt_q[2:0];
              wr_data_d = byte_val;
            end
          end
        end

        S_TURN: begin
          if (sclk_rise) begin
            if (!turn_q) begin
              turn_d = 1'b1;
            end else begin
              out_cnt_d = 5'd0;
              sio_oe_d  = 1'b1;
              if (is_stat_q) begin
                state_d   = S_STAT;
                shift_d   = {7'b0, busy_q, 8'h00};
                sio_out_d = 4'h0;
              end else begin
                state_d   = S_READ;
                shift_d   = rd_data;
                sio_out_d = rd_data[15:12];
                adv_d     = 1'b1;
              end
            end
          end
        end

        S_READ: begin
          if (sclk_fall && out_cnt_q < 5'd16) begin
            out_cnt_d = out_cnt_q + 5'd1;
            if (out_cnt_q == 5'd15) begin
              sio_oe_d  = 1'b0;
              sio_out_d = 4'h0;
            end else if (out_cnt_q[1:0] == 2'b11) begin
              // First nibble of the next word: capture it whole.
              shift_d   = rd_data;
              sio_out_d = rd_data[15:12];
              adv_d     = 1'b1;
            end else begin
              sio_out_d = shift_q[11:8];
              shift_d   = {shift_q[11:0], 4'h0};
            end
          end
        end

        S_STAT: begin
          if (sclk_fall && out_cnt_q < 5'd2) begin
            out_cnt_d = out_cnt_q + 5'd1;
            if (out_cnt_q == 5'd1) begin
              sio_oe_d  = 1'b0;
              sio_out_d = 4'h0;
            end else begin
              sio_out_d = shift_q[11:8];
              shift_d   = {shift_q[11:0], 4'h0};
            end
          end
        end

        default: ;
      endcase
    end

    // A start on the same clk as a done wins: the new compute is in flight.
    if (mm_start_d)   busy_d = 1'b1;
    else if (mm_done) busy_d = 1'b0;
    else              busy_d = busy_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      nib_q      <= 1'b0;
      hi_q       <= 4'h0;
      wr_cnt_q   <= 4'd0;
      turn_q     <= 1'b0;
      is_stat_q  <= 1'b0;
      out_cnt_q  <= 5'd0;
      shift_q    <= 16'h0;
      adv_q      <= 1'b0;
      sio_out_q  <= 4'h0;
      sio_oe_q   <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= 3'd0;
      wr_data_q  <= 8'h00;
      mm_start_q <= 1'b0;
      rd_addr_q  <= 2'd0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      nib_q      <= nib_d;
      hi_q       <= hi_d;
      wr_cnt_q   <= wr_cnt_d;
      turn_q     <= turn_d;
      is_stat_q  <= is_stat_d;
      out_cnt_q  <= out_cnt_d;
      shift_q    <= shift_d;
      adv_q      <= adv_d;
      sio_out_q  <= sio_out_d;
      sio_oe_q   <= sio_oe_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      mm_start_q <= mm_start_d;
      rd_addr_q  <= rd_addr_d;
      busy_q     <= busy_d;
    end
  end

  assign sio_out  = sio_out_q;
  assign sio_oe   = sio_oe_q;
  assign wr_en    = wr_en_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign mm_start = mm_start_q;
  assign rd_addr  = rd_addr_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_qspi_mm_ctrl.sv
// Directed + randomized bench for qspi_mm_ctrl. The host side is driven
// as QSPI frames; a small result-memory model answers rd_addr, and the
// expected operand writes / nibble stream are computed from the command
// rules directly.
module tb_qspi_mm_ctrl;

  logic        clk = 1'b0;
  logic        rst, cs_n, sclk, mm_done;
  logic [3:0]  sio_in;
  logic [3:0]  sio_out;
  logic        sio_oe, wr_en, mm_start, busy;
  logic [2:0]  wr_addr;
  logic [7:0]  wr_data;
  logic [1:0]  rd_addr;
  logic [15:0] rd_data;

  logic [15:0] words [4];
  logic [2:0]  wa_q [$];
  logic [7:0]  wd_q [$];
  logic [7:0]  payload [$];
  int          start_cnt = 0;
  int          tests = 0;
  int          fails = 0;

  always #5 clk = ~clk;

  qspi_mm_ctrl #(.SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .cs_n(cs_n), .sclk(sclk), .sio_in(sio_in),
    .sio_out(sio_out), .sio_oe(sio_oe), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .mm_start(mm_start), .mm_done(mm_done),
    .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy)
  );

  // Result memory: selected word appears one clk after rd_addr.
  always @(posedge clk) rd_data <= words[rd_addr];

  // Record every write-port pulse and start pulse, sampled mid-cycle.
  always @(negedge clk) begin
    if (wr_en) begin
      wa_q.push_back(wr_addr);
      wd_q.push_back(wr_data);
    end
    if (mm_start) start_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic half();
    repeat (8) @(posedge clk);
    #1;
  endtask

  task automatic rise();  sclk = 1'b1; half(); endtask
  task automatic fall();  sclk = 1'b0; half(); endtask
  task automatic cs_low();  cs_n = 1'b0; half(); endtask
  task automatic cs_high(); cs_n = 1'b1; half(); half(); endtask

  task automatic send_nib(input logic [3:0] v);
    sio_in = v;
    rise();
    fall();
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_nib(b[7:4]);
    send_nib(b[3:0]);
  endtask

  // Expected writes: payload byte n goes to slot n, only the first eight,
  // and nothing at all when the load was not accepted.
  task automatic check_writes(input string tag, input bit accepted);
    int n;
    n = accepted ? ((payload.size() > 8) ? 8 : payload.size()) : 0;
    check({tag, "_count"}, wa_q.size(), n);
    for (int i = 0; i < n && i < wa_q.size(); i++) begin
      check({tag, "_addr"}, wa_q[i], i);
      check({tag, "_data"}, wd_q[i], payload[i]);
    end
    wa_q.delete();
    wd_q.delete();
  endtask

  task automatic load_frame(input string tag, input bit accepted);
    wa_q.delete();
    wd_q.delete();
    cs_low();
    send_byte(8'h01);
    foreach (payload[i]) send_byte(payload[i]);
    cs_high();
    check_writes(tag, accepted);
  endtask

  task automatic stat_frame(input string tag, input logic b);
    cs_low();
    send_byte(8'h04);
    check({tag, "_turn_oe_a"}, sio_oe, 1'b0);
    sio_in = 4'h0;
    rise();
    check({tag, "_turn_oe_b"}, sio_oe, 1'b0);
    fall();
    check({tag, "_turn_oe_c"}, sio_oe, 1'b0);
    rise();
    check({tag, "_oe_on"}, sio_oe, 1'b1);
    check({tag, "_nib_hi"}, sio_out, 4'h0);
    fall();
    check({tag, "_nib_lo"}, sio_out, {3'b000, b});
    rise();
    fall();
    check({tag, "_oe_off"}, sio_oe, 1'b0);
    cs_high();
  endtask

  task automatic read_frame(input string tag);
    logic [15:0] w;
    logic [3:0]  e;
    cs_low();
    send_byte(8'h03);
    check({tag, "_turn_oe_a"}, sio_oe, 1'b0);
    sio_in = 4'h0;
    rise();
    check({tag, "_turn_oe_b"}, sio_oe, 1'b0);
    fall();
    rise();
    check({tag, "_oe_on"}, sio_oe, 1'b1);
    check({tag, "_nib0"}, sio_out, words[0][15:12]);
    for (int i = 1; i < 16; i++) begin
      fall();
      w = words[i / 4];
      e = 4'((w >> (12 - 4 * (i % 4))) & 16'h000F);
      check({tag, "_nib"}, sio_out, e);
      check({tag, "_oe_held"}, sio_oe, 1'b1);
      rise();
    end
    fall();
    check({tag, "_oe_off"}, sio_oe, 1'b0);
    check({tag, "_out_zero"}, sio_out, 4'h0);
    rise();
    fall();
    check({tag, "_out_stays_zero"}, sio_out, 4'h0);
    cs_high();
  endtask

  initial begin
    int  s0;
    bit  model_busy;
    rst = 1'b1; cs_n = 1'b1; sclk = 1'b0; sio_in = 4'h0; mm_done = 1'b0;
    words[0] = 16'h1234; words[1] = 16'h5678;
    words[2] = 16'h9ABC; words[3] = 16'hDEF0;
    model_busy = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("rst_sio_out", sio_out, 4'h0);
    check("rst_sio_oe", sio_oe, 1'b0);
    check("rst_wr_en", wr_en, 1'b0);
    check("rst_wr_addr", wr_addr, 3'd0);
    check("rst_wr_data", wr_data, 8'h00);
    check("rst_mm_start", mm_start, 1'b0);
    check("rst_rd_addr", rd_addr, 2'd0);
    check("rst_busy", busy, 1'b0);
    rst = 1'b0;
    half();

    // Fixed load: eight bytes land, the ninth is dropped.
    payload = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h99};
    load_frame("load_fixed", 1'b1);

    // Unknown command: nothing written, no start, bus never driven.
    s0 = start_cnt;
    wa_q.delete(); wd_q.delete();
    payload = '{};
    cs_low();
    send_byte(8'h7F);
    for (int i = 0; i < 3; i++) send_byte(8'($urandom));
    check("ignore_oe", sio_oe, 1'b0);
    cs_high();
    check_writes("ignore", 1'b0);
    check("ignore_start", start_cnt, s0);

    // RUN starts a compute once; a second RUN while busy is a no-op.
    s0 = start_cnt;
    cs_low();
    send_byte(8'h02);
    if (!model_busy) begin
      model_busy = 1'b1;
      s0++;
    end
    check("run_busy", busy, model_busy);
    cs_high();
    check("run_start_cnt", start_cnt, s0);
    cs_low();
    send_byte(8'h02);
    cs_high();
    check("run2_start_cnt", start_cnt, s0);
    check("run2_busy", busy, model_busy);

    // Loads while busy are discarded.
    payload = '{8'($urandom), 8'($urandom), 8'($urandom)};
    load_frame("load_busy", !model_busy);

    stat_frame("stat_busy1", model_busy);

    @(posedge clk); #1;
    mm_done = 1'b1;
    @(posedge clk); #1;
    mm_done = 1'b0;
    model_busy = 1'b0;
    check("done_busy", busy, model_busy);

    stat_frame("stat_busy0", model_busy);
    read_frame("read_fixed");

    for (int k = 0; k < 4; k++) words[k] = 16'($urandom);
    read_frame("read_rand");

    payload.delete();
    for (int i = 0; i < int'($urandom_range(1, 11)); i++) payload.push_back(8'($urandom));
    load_frame("load_rand", 1'b1);

    // A partial nibble left by an aborted frame must not leak into the next.
    cs_low();
    send_byte(8'h01);
    send_nib(4'hA);
    cs_high();
    payload = '{8'($urandom)};
    load_frame("load_after_abort", 1'b1);

    // Reset mid-frame with cs_n held low: no frame until a fresh cs_n fall.
    wa_q.delete(); wd_q.delete();
    cs_low();
    send_byte(8'h01);
    send_nib(4'h5);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    half();
    send_byte(8'h01);
    send_byte(8'h55);
    send_byte(8'h66);
    check("rstmid_oe", sio_oe, 1'b0);
    cs_high();
    payload = '{};
    check_writes("rstmid", 1'b0);
    payload = '{8'hC3};
    load_frame("load_after_rst", 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
